// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens, word-align FSM states and the 10b->8b decode shared by TX/RX
package tmds_pkg;
    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;
    typedef enum logic [1:0] {SEARCH, SETTLE, LOCKED} align_state_t;
    function automatic logic is_token(input logic [9:0] w);
        return w == TOKEN_00 || w == TOKEN_01 || w == TOKEN_10 || w == TOKEN_11;
    endfunction
    // {C1,C0} carried by a control token
    function automatic logic [1:0] token_bits(input logic [9:0] w);
        return w == TOKEN_11 ? 2'b11 : w == TOKEN_10 ? 2'b10 : w == TOKEN_01 ? 2'b01 : 2'b00;
    endfunction
    function automatic logic [7:0] tmds_decode_8b(input logic [9:0] w);
        logic [7:0] d;
        d = w[9] ? ~w[7:0] : w[7:0];
        return {d[7:1] ^ d[6:0] ^ {7{~w[8]}}, d[0]};
    endfunction
endpackage

// File: rtl/tmds_word_align.sv
// tmds_word_align: word-boundary search via bitslip, lock from control-token runs, lock-loss watchdog
module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int SEARCH_WINDOW = 4096,
    parameter int CTRL_RUN_LOCK = 8,
    parameter int SLIP_SETTLE   = 4,
    parameter int LOSS_WINDOW   = 8192
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       is_ctrl,
    output logic       bitslip,
    output logic       locked,
    output logic [3:0] slip_cnt
);
    localparam int RW = $clog2(CTRL_RUN_LOCK) + 1;
    localparam int WW = $clog2(SEARCH_WINDOW) + 1;
    localparam int SW = $clog2(SLIP_SETTLE) + 1;
    localparam int LW = $clog2(LOSS_WINDOW) + 1;
    align_state_t state, state_nx;
    logic [RW-1:0] run;
    logic [WW-1:0] win;
    logic [SW-1:0] settle;
    logic [LW-1:0] loss;
    logic run_hit, win_hit, settle_done, loss_hit;
    assign run_hit     = run == RW'(CTRL_RUN_LOCK);
    assign win_hit     = win == WW'(SEARCH_WINDOW - 1);
    assign settle_done = settle == SW'(SLIP_SETTLE - 1);
    assign loss_hit    = loss == LW'(LOSS_WINDOW - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) state <= SEARCH;
        else state <= state_nx;
    end
    // lock beats a simultaneous window expiry or loss expiry
    always_comb begin
        state_nx = state == SEARCH ? (run_hit ? LOCKED : win_hit ? SETTLE : SEARCH)
                 : state == SETTLE ? (settle_done ? SEARCH : SETTLE)
                 : (loss_hit && !run_hit ? SEARCH : LOCKED);
    end
    always_comb begin
        bitslip = state == SEARCH && win_hit && !run_hit;
        locked  = state == LOCKED;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run      <= '0;
            win      <= '0;
            settle   <= '0;
            loss     <= '0;
            slip_cnt <= 4'd0;
        end else begin
            run      <= state == SETTLE || !is_ctrl ? '0 : run_hit ? run : run + 1'b1;
            win      <= state == SEARCH && state_nx == SEARCH ? win + 1'b1 : '0;
            settle   <= state == SETTLE && !settle_done ? settle + 1'b1 : '0;
            loss     <= state == LOCKED && !run_hit && !loss_hit ? loss + 1'b1 : '0;
            slip_cnt <= bitslip ? (slip_cnt == 4'd9 ? 4'd0 : slip_cnt + 4'd1)
                      : state == LOCKED && state_nx == SEARCH ? 4'd0 : slip_cnt;
        end
    end
endmodule

// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: one TMDS receive channel -- alignment, lock and 10b->8b/control decode
module tmds_rx_decoder
    import tmds_pkg::*;
#(
    parameter int SEARCH_WINDOW = 4096,
    parameter int CTRL_RUN_LOCK = 8,
    parameter int SLIP_SETTLE   = 4,
    parameter int LOSS_WINDOW   = 8192
) (
    input  logic       PXLCLK_I,
    input  logic       RST_N,
    input  logic [9:0] TMDS_WORD_I,
    output logic       BITSLIP_O,
    output logic       LOCKED_O,
    output logic [3:0] SLIP_CNT_O,
    output logic       DE_O,
    output logic       C0_O,
    output logic       C1_O,
    output logic [7:0] DATA_O
);
    logic [9:0] word_s1;
    logic       ctrl_s1;
    logic       de_s2;
    logic [1:0] c_s2;
    logic [7:0] data_s2;
    tmds_word_align #(
        .SEARCH_WINDOW(SEARCH_WINDOW),
        .CTRL_RUN_LOCK(CTRL_RUN_LOCK),
        .SLIP_SETTLE(SLIP_SETTLE),
        .LOSS_WINDOW(LOSS_WINDOW)
    ) u_align (
        .clk(PXLCLK_I),
        .rst_n(RST_N),
        .is_ctrl(ctrl_s1),
        .bitslip(BITSLIP_O),
        .locked(LOCKED_O),
        .slip_cnt(SLIP_CNT_O)
    );
    always_ff @(posedge PXLCLK_I) begin
        if (!RST_N) begin
            word_s1 <= '0;
            ctrl_s1 <= 1'b0;
            de_s2   <= 1'b0;
            c_s2    <= 2'b00;
            data_s2 <= '0;
        end else begin
            word_s1 <= TMDS_WORD_I;
            ctrl_s1 <= is_token(TMDS_WORD_I);
            de_s2   <= !ctrl_s1;
            c_s2    <= ctrl_s1 ? token_bits(word_s1) : c_s2;
            data_s2 <= ctrl_s1 ? '0 : tmds_decode_8b(word_s1);
        end
    end
    // gating on the live lock flag makes outputs drop in the same cycle lock is lost
    assign DE_O         = LOCKED_O & de_s2;
    assign {C1_O, C0_O} = LOCKED_O ? c_s2 : 2'b00;
    assign DATA_O       = LOCKED_O ? data_s2 : 8'h00;
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb_tmds_rx_decoder: randomized stream through a rotating-deserializer model, checked against a behavioural model
module tb_tmds_rx_decoder;
    localparam int SW = 64, RL = 8, SS = 4, LW = 128;
    localparam logic [9:0] T00 = 10'b1101010100, T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100, T11 = 10'b1010101011;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [9:0] word = '0;
    logic bitslip, locked, de, c0, c1;
    logic [3:0] slip_cnt;
    logic [7:0] data;
    int total = 0, bad = 0, cyc = 0;
    int offset = 0, pulses = 0, last_pulse = 0, gap = 0;
    bit m_lock, m_de;
    int m_settle, m_age, m_since, m_streak, m_slips;
    logic [9:0] m_p1;
    logic [1:0] m_c;
    logic [7:0] m_data;

    tmds_rx_decoder #(.SEARCH_WINDOW(SW), .CTRL_RUN_LOCK(RL), .SLIP_SETTLE(SS), .LOSS_WINDOW(LW)) dut (
        .PXLCLK_I(clk), .RST_N(rst_n), .TMDS_WORD_I(word), .BITSLIP_O(bitslip), .LOCKED_O(locked),
        .SLIP_CNT_O(slip_cnt), .DE_O(de), .C0_O(c0), .C1_O(c1), .DATA_O(data)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit tok(input logic [9:0] w);
        return w inside {T00, T01, T10, T11};
    endfunction
    function automatic logic [1:0] tok_c(input logic [9:0] w);
        logic [9:0] toks [4] = '{T00, T01, T10, T11};
        logic [1:0] c = 2'b00;
        for (int i = 0; i < 4; i++) if (w == toks[i]) c = 2'(i);
        return c;
    endfunction
    function automatic logic [7:0] dec(input logic [9:0] w);
        logic [7:0] d, q;
        d = w[9] ? ~w[7:0] : w[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = w[8] ? d[i] ^ d[i-1] : !(d[i] ^ d[i-1]);
        return q;
    endfunction
    function automatic logic [9:0] rot(input logic [9:0] w, input int n);
        logic [9:0] r;
        r = (w >> n) | (w << (10 - n));
        return r;
    endfunction
    function automatic bit any_rot_tok(input logic [9:0] w);
        bit t = 0;
        for (int r = 0; r < 10; r++) if (tok(rot(w, r))) t = 1;
        return t;
    endfunction
    function automatic logic [9:0] rand_data();
        logic [9:0] w = 10'($urandom);
        while (any_rot_tok(w)) w = 10'($urandom);
        return w;
    endfunction

    task automatic m_reset();
        m_lock = 0; m_de = 0; m_settle = 0; m_age = 0; m_since = 0; m_streak = 0; m_slips = 0;
        m_p1 = '0; m_c = 2'b00; m_data = '0;
    endtask

    // reference: streak of tokens seen by the aligner, cycles spent searching/settling/since last refresh
    task automatic model_edge(input bit r, input logic [9:0] w);
        bit hit;
        int nstreak;
        if (!r) begin
            m_reset();
            return;
        end
        hit = m_streak == RL;
        if (tok(m_p1)) begin
            m_de = 0; m_data = '0; m_c = tok_c(m_p1);
        end else begin
            m_de = 1; m_data = dec(m_p1);
        end
        nstreak = m_settle > 0 || !tok(m_p1) ? 0 : (m_streak + 1 > RL ? RL : m_streak + 1);
        if (m_lock) begin
            if (hit) m_since = 0;
            else if (m_since == LW - 1) begin m_lock = 0; m_age = 0; m_slips = 0; end
            else m_since++;
        end else if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) m_age = 0;
        end else if (hit) begin
            m_lock = 1; m_since = 0;
        end else if (m_age == SW - 1) begin
            m_slips = (m_slips + 1) % 10; m_settle = SS;
        end else m_age++;
        m_streak = nstreak;
        m_p1 = w;
    endtask

    task automatic step(input logic [9:0] raw, input bit r = 1);
        logic [9:0] w;
        w = rot(raw, offset % 10);
        rst_n = r;
        word = w;
        model_edge(r, w);
        @(posedge clk);
        #1;
        cyc++;
        check("bitslip", bitslip, !m_lock && m_settle == 0 && m_streak != RL && m_age == SW - 1);
        check("locked", locked, m_lock);
        check("slip_cnt", slip_cnt, m_slips);
        check("de", de, m_lock && m_de);
        check("c0", c0, m_lock && m_c[0]);
        check("c1", c1, m_lock && m_c[1]);
        check("data", data, m_lock ? m_data : 8'h00);
        if (bitslip) begin
            offset++; pulses++; gap = cyc - last_pulse; last_pulse = cyc;
        end
    endtask

    initial begin
        int lock_step, fall, prev_cnt;
        bit wrapped, ever_locked;
        m_reset();
        repeat (3) begin
            step(10'($urandom), 0);
            check("t1_reset_outs", {bitslip, locked, slip_cnt, de, c0, c1, data}, 0);
        end
        lock_step = 0;
        for (int i = 1; i <= 16; i++) begin
            step(T00);
            if (locked && lock_step == 0) lock_step = i;
        end
        check("t2_lock_step", lock_step, 10);
        step(10'b0100000000);
        step(10'b0111111111);
        check("t2_de_a", de, 1);
        check("t2_data_a", data, 8'h00);
        step(10'b1011111111);
        check("t2_data_b", data, 8'h01);
        step(T00);
        check("t2_data_c", data, 8'hFE);
        check("t2_de_c", de, 1);
        step(T00, 0);
        step(T00, 0);
        offset = 7; pulses = 0;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 20; i++) begin
                step(T00);
                if (bitslip && pulses > 1) check("t3_gap_ge64", gap >= SW, 1);
            end
            for (int i = 0; i < 40; i++) begin
                step(rand_data());
                if (bitslip && pulses > 1) check("t3_gap_ge64", gap >= SW, 1);
            end
        end
        check("t3_pulses", pulses, 3);
        check("t3_locked", locked, 1);
        check("t3_slip_cnt", slip_cnt, 3);
        repeat (16) step(T00);
        fall = 0;
        for (int i = 1; i <= 140; i++) begin
            step(rand_data());
            if (!locked && fall == 0) begin
                fall = i;
                check("t4_de_at_fall", de, 0);
                check("t4_cnt_at_fall", slip_cnt, 0);
            end
        end
        check("t4_fall_step", fall, 2 + LW);
        step(T00, 0);
        offset = 0; pulses = 0; wrapped = 0; ever_locked = 0; prev_cnt = 0;
        for (int p = 0; p < 70; p++) begin
            for (int i = 0; i < 12; i++) begin
                step(i < 7 ? T00 : rand_data());
                if (bitslip && pulses > 1) check("t5_gap", gap, SW + SS);
                if (prev_cnt == 9 && slip_cnt == 0) wrapped = 1;
                prev_cnt = int'(slip_cnt);
                if (locked) ever_locked = 1;
            end
        end
        check("t5_never_locked", ever_locked, 0);
        check("t5_wrapped", wrapped, 1);
        check("t5_many_slips", pulses >= 10, 1);
        step(T00, 0);
        offset = 0;
        repeat (16) step(T00);
        repeat (4) step(T01);
        check("t6_c0", c0, 1);
        check("t6_c1", c1, 0);
        check("t6_de", de, 0);
        check("t6_locked", locked, 1);
        step(rand_data(), 0);
        check("t6_reset_outs", {bitslip, locked, slip_cnt, de, c0, c1, data}, 0);
        repeat (4) step(T11);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
